uart_tx_param: RTL and testbench
================================

// Module: uart_tx_param
// PURPOSE
//  Parametrised 8N1-successor UART transmitter: serialises one DATA_BITS-wide word per frame
//  (start, data LSB-first, optional parity, 1 or 2 stop bits) at clk/CLKS_PER_BIT baud.
//  Internal baud divider and a valid/ready input handshake.
//  Sits between a byte producer (FIFO, command sequencer) and the board tx pin.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per serial bit (>=2; 868 = 115200 baud at 100 MHz)
//  DATA_BITS     8    data bits per frame, 5..9
//  STOP_BITS     1    stop bits per frame, 1 or 2
//  PARITY_ODD    0    0 = even parity, 1 = odd parity; only used when UART_TX_PARITY_EN is defined
// PORTS
//  clk       in   1          system clock, all logic on posedge
//  rst_n     in   1          asynchronous active-low reset
//  tx_data   in   DATA_BITS  word to send, sampled on accept
//  tx_valid  in   1          producer has a word
//  tx_ready  out  1          block can accept; accept = tx_valid & tx_ready on posedge clk
//  tx_busy   out  1          frame in progress
//  txdone    out  1          one-cycle pulse: final stop bit completed
//  tx        out  1          serial line, idles high
// BEHAVIOUR
//  Reset (async assert, sync release): tx=1, tx_ready=1, tx_busy=0, txdone=0, state=IDLE, counters 0.
//   Reset mid-frame aborts the frame immediately; line returns high; partial word is lost.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: tx=1, tx_ready=1. On accept: latch tx_data into shift reg, clear parity acc, go START.
//   START: tx=0 for CLKS_PER_BIT cycles.
//   DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right and XOR bit into parity acc
//    at each bit end; after DATA_BITS bits go PARITY (macro on) or STOP.
//   PARITY: tx=acc^PARITY_ODD for CLKS_PER_BIT cycles.
//   STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; on last cycle: txdone=1, tx_ready=1, go IDLE.
//  Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, wraps at bit end; reset
//   to 0 on accept so every bit is exactly CLKS_PER_BIT cycles. Bit counter: $clog2(DATA_BITS+1).
//  Latency: tx falls on the cycle after accept (all outputs registered).
//  Frame length exactly (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, P = 1 if parity else 0.
//  tx_ready is high during the last STOP cycle (the txdone cycle), so an accept in the txdone
//   cycle starts the next frame with zero idle gap; tx_busy stays 1 across that handoff.
//  tx_valid while tx_ready=0 is ignored; producer holds it, no data is dropped.
//  tx_data changes after accept have no effect on the frame in flight.
//  tx_ready=0 outside IDLE and the last STOP cycle; tx_busy=1 from the cycle after accept
//   until the cycle after the final stop-bit cycle, when no new word is accepted.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state inserted after DATA, PARITY_ODD selects sense.
//  Undefined: no PARITY state or parity accumulator, P=0, PARITY_ODD ignored.
// STRUCTURE
//  Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP) and the baud-width helper
//   function, shared with the future uart_rx_param.
//  Sub-module uart_baud_gen (parameter CLKS_PER_BIT): counter with sync clear and a bit_end
//   strobe; also reused by RX.
// TESTING (CLKS_PER_BIT=4 unless noted; sample tx mid-bit)
//  1. DATA_BITS=8, no parity; send 0x55 -> tx 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop),
//     each 4 cycles; txdone pulses once at cycle 40 after accept.
//  2. Back-to-back 0xA5 then 0x3C, tx_valid held -> second start bit directly after first stop
//     bit, zero idle cycles; tx_busy never drops between frames.
//  3. Macro on, PARITY_ODD=0; send 0x07 -> parity bit 1. PARITY_ODD=1 -> parity bit 0.
//     Frame is 44 cycles.
//  4. Assert rst_n low during DATA bit 3 -> tx=1, tx_ready=1, tx_busy=0 at once; after release,
//     send 0x81 -> frame is correct.
//  5. Pulse tx_valid with 0xFF mid-frame while tx_ready=0 -> ignored; only the first word is sent.
//  6. DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=2; send 0x13 -> 0,1,1,0,0,1,1,1; 16 cycles total.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the baud-counter width helper,
// common to uart_tx_param and the receiver that will reuse them.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Width of a counter running 0..clks_per_bit-1; never narrower than one bit.
  function automatic int baud_width(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Producer-side handshake and line outputs of the parametrised UART transmitter.
// master = byte producer, slave = transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 txdone;
  logic                 tx;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_busy,
    input  txdone,
    input  tx
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_busy,
    output txdone,
    output tx
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high, wraps at bit end,
// and restarts from zero on a synchronous clear. Also used by the receiver.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic bit_end,
  output logic bit_end_next
);

  localparam int            CW   = baud_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (!clear && run && (cnt_reg != LAST)) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign bit_end      = run && (cnt_reg == LAST);
  // Lets the owner register outputs that must be high during the last cycle of a bit.
  assign bit_end_next = (cnt_next == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1..2 stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit (sense chosen by PARITY_ODD).
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_param_if.slave  bus
);

  localparam int               BIT_W     = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic                 stop_cnt_reg, stop_cnt_next;
`ifdef UART_TX_PARITY_EN
  logic                 parity_reg, parity_next;
`endif

  logic tx_reg, tx_next;
  logic ready_reg, ready_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;

  logic accept;
  logic run;
  logic bit_end;
  logic bit_end_next;

  assign accept = bus.tx_valid && ready_reg;
  assign run    = (state_reg != IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (accept),
    .run          (run),
    .bit_end      (bit_end),
    .bit_end_next (bit_end_next)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
`ifdef UART_TX_PARITY_EN
    parity_next   = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        state_next = IDLE;
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next  = shift_reg >> 1;
`ifdef UART_TX_PARITY_EN
          parity_next = parity_reg ^ shift_reg[0];
`endif
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_reg == LAST_STOP) begin
            stop_cnt_next = 1'b0;
            state_next    = IDLE;
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // ready is only high in IDLE or the final stop cycle, so an accept always starts a fresh frame.
    if (accept) begin
      state_next    = START;
      shift_next    = bus.tx_data;
      bit_cnt_next  = '0;
      stop_cnt_next = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_next   = 1'b0;
`endif
    end
  end

  // Outputs are decoded from the next state so that the registered copies line up with it.
  always_comb begin
    tx_next    = 1'b1;
    done_next  = (state_next == STOP) && (stop_cnt_next == LAST_STOP) && bit_end_next;
    ready_next = (state_next == IDLE) || done_next;
    busy_next  = (state_next != IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next ^ 1'(PARITY_ODD);
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_reg    <= 1'b1;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      tx_reg    <= tx_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.tx       = tx_reg;
  assign bus.tx_ready = ready_reg;
  assign bus.tx_busy  = busy_reg;
  assign bus.txdone   = done_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param: three instances cover the 8N1, 5-bit/2-stop
// and odd-parity configurations; parity frames are checked when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) ifa ();
  uart_tx_param_if #(.DATA_BITS(5)) ifb ();
  uart_tx_param_if #(.DATA_BITS(8)) ifc ();

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  uart_tx_param #(.CLKS_PER_BIT(2), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Present a word on instance a and return just after the accepting posedge.
  task automatic start_a(input logic [7:0] d, output bit ok);
    int k = 0;
    @(negedge clk);
    ifa.tx_data  = d;
    ifa.tx_valid = 1'b1;
    while (ifa.tx_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    ok = (k < 200);
    @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (ifa.tx !== 1'b1) begin n_fail++; $display("FAIL rst_a_tx got %b want 1", ifa.tx); end
    n_checks++; if (ifa.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_ready got %b want 1", ifa.tx_ready); end
    n_checks++; if (ifa.tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_a_busy got %b want 0", ifa.tx_busy); end
    n_checks++; if (ifa.txdone !== 1'b0) begin n_fail++; $display("FAIL rst_a_done got %b want 0", ifa.txdone); end
    n_checks++; if (ifb.tx !== 1'b1) begin n_fail++; $display("FAIL rst_b_tx got %b want 1", ifb.tx); end
    n_checks++; if (ifb.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_b_ready got %b want 1", ifb.tx_ready); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (ifa.tx !== 1'b1 || ifa.tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_a got tx=%b busy=%b want tx=1 busy=0", ifa.tx, ifa.tx_busy);
    end
    n_checks++; if (ifa.tx_ready !== 1'b1) begin n_fail++; $display("FAIL idle_a_ready got %b want 1", ifa.tx_ready); end
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_single_frame();
    logic [9:0] exp = 10'b1010101010;
    int done_cnt = 0;
    int done_at = -1;
    bit ok;
    start_a(8'h55, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_accept got timeout want accept"); end
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      if (c == 0) ifa.tx_valid = 1'b0;
      if (c < 40 && c % 4 == 2) begin
        n_checks++;
        if (ifa.tx !== exp[c/4]) begin n_fail++; $display("FAIL single_bit%0d got %b want %b", c/4, ifa.tx, exp[c/4]); end
      end
      if (ifa.txdone === 1'b1) begin done_cnt++; done_at = c; end
      if (c == 39) begin
        n_checks++; if (ifa.tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy39 got %b want 1", ifa.tx_busy); end
      end
      if (c == 40) begin
        n_checks++; if (ifa.tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy40 got %b want 0", ifa.tx_busy); end
      end
    end
    n_checks++; if (done_cnt != 1 || done_at != 39) begin
      n_fail++; $display("FAIL single_done got count=%0d at=%0d want count=1 at=39", done_cnt, done_at);
    end
    $display("frame a: sent 0x55, txdone at cycle %0d", done_at);
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp1 = 10'b1101001010;
    logic [9:0] exp2 = 10'b1001111000;
    int  done_cnt = 0;
    bit  busy_drop = 1'b0;
    bit  ok;
    start_a(8'hA5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_accept got timeout want accept"); end
    for (int c = 0; c < 84; c++) begin
      @(negedge clk);
      if (c == 0) ifa.tx_data = 8'h3C;
      if (c == 40) ifa.tx_valid = 1'b0;
      if (c < 40 && c % 4 == 2) begin
        n_checks++;
        if (ifa.tx !== exp1[c/4]) begin n_fail++; $display("FAIL b2b_w1_bit%0d got %b want %b", c/4, ifa.tx, exp1[c/4]); end
      end
      if (c >= 40 && c < 80 && c % 4 == 2) begin
        n_checks++;
        if (ifa.tx !== exp2[(c-40)/4]) begin n_fail++; $display("FAIL b2b_w2_bit%0d got %b want %b", (c-40)/4, ifa.tx, exp2[(c-40)/4]); end
      end
      if (c == 39) begin
        n_checks++; if (ifa.tx_ready !== 1'b1 || ifa.txdone !== 1'b1) begin
          n_fail++; $display("FAIL b2b_handoff got ready=%b done=%b want 1 1", ifa.tx_ready, ifa.txdone);
        end
      end
      if (c == 40) begin
        n_checks++; if (ifa.tx !== 1'b0 || ifa.tx_ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b_gap got tx=%b ready=%b want 0 0", ifa.tx, ifa.tx_ready);
        end
      end
      if (c < 80 && ifa.tx_busy !== 1'b1) busy_drop = 1'b1;
      if (ifa.txdone === 1'b1) done_cnt++;
      if (c == 80) begin
        n_checks++; if (ifa.tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got %b want 0", ifa.tx_busy); end
      end
    end
    n_checks++; if (busy_drop) begin n_fail++; $display("FAIL b2b_busy got drop want steady 1"); end
    n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
    $display("frame a: sent 0xA5 then 0x3C back to back");
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp = 10'b1100000010;
    int  done_at = -1;
    bit  ok;
    start_a(8'hF0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_accept got timeout want accept"); end
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (c == 0) ifa.tx_valid = 1'b0;
    end
    n_checks++; if (ifa.tx !== 1'b0 || ifa.tx_busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre got tx=%b busy=%b want 0 1", ifa.tx, ifa.tx_busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (ifa.tx !== 1'b1 || ifa.tx_ready !== 1'b1 || ifa.tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async got tx=%b ready=%b busy=%b want 1 1 0", ifa.tx, ifa.tx_ready, ifa.tx_busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_a(8'h81, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_accept2 got timeout want accept"); end
    for (int c = 0; c < 42; c++) begin
      @(negedge clk);
      if (c == 0) ifa.tx_valid = 1'b0;
      if (c < 40 && c % 4 == 2) begin
        n_checks++;
        if (ifa.tx !== exp[c/4]) begin n_fail++; $display("FAIL midrst_bit%0d got %b want %b", c/4, ifa.tx, exp[c/4]); end
      end
      if (ifa.txdone === 1'b1) done_at = c;
    end
    n_checks++; if (done_at != 39) begin n_fail++; $display("FAIL midrst_done got %0d want 39", done_at); end
    $display("frame a: reset during 0xF0, then sent 0x81");
  endtask

  task automatic test_ignore_valid();
    logic [9:0] exp = 10'b1100101100;
    bit  extra = 1'b0;
    bit  ok;
    start_a(8'h96, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ignore_accept got timeout want accept"); end
    for (int c = 0; c < 52; c++) begin
      @(negedge clk);
      if (c == 0) ifa.tx_valid = 1'b0;
      if (c == 10) begin ifa.tx_data = 8'hFF; ifa.tx_valid = 1'b1; end
      if (c == 12) begin
        n_checks++; if (ifa.tx_ready !== 1'b0) begin n_fail++; $display("FAIL ignore_ready got %b want 0", ifa.tx_ready); end
        ifa.tx_valid = 1'b0;
      end
      if (c < 40 && c % 4 == 2) begin
        n_checks++;
        if (ifa.tx !== exp[c/4]) begin n_fail++; $display("FAIL ignore_bit%0d got %b want %b", c/4, ifa.tx, exp[c/4]); end
      end
      if (c >= 40 && (ifa.tx !== 1'b1 || ifa.tx_busy !== 1'b0)) extra = 1'b1;
    end
    n_checks++; if (extra) begin n_fail++; $display("FAIL ignore_after got extra activity want idle"); end
    $display("frame a: sent 0x96, mid-frame 0xFF ignored");
  endtask

  task automatic test_short_frame();
    logic [7:0] exp = 8'b11100110;
    int  done_cnt = 0;
    int  done_at = -1;
    int  k = 0;
    @(negedge clk);
    ifb.tx_data  = 5'h13;
    ifb.tx_valid = 1'b1;
    while (ifb.tx_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    n_checks++; if (k >= 200) begin n_fail++; $display("FAIL short_accept got timeout want accept"); end
    @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) ifb.tx_valid = 1'b0;
      if (c < 16 && c % 2 == 1) begin
        n_checks++;
        if (ifb.tx !== exp[c/2]) begin n_fail++; $display("FAIL short_bit%0d got %b want %b", c/2, ifb.tx, exp[c/2]); end
      end
      if (ifb.txdone === 1'b1) begin done_cnt++; done_at = c; end
      if (c == 16) begin
        n_checks++; if (ifb.tx_busy !== 1'b0) begin n_fail++; $display("FAIL short_busy_end got %b want 0", ifb.tx_busy); end
      end
    end
    n_checks++; if (done_cnt != 1 || done_at != 15) begin
      n_fail++; $display("FAIL short_done got count=%0d at=%0d want count=1 at=15", done_cnt, done_at);
    end
    $display("frame b: sent 0x13 as 5 data bits, 2 stop bits");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] exp_even = 11'b11000001110;
    logic [10:0] exp_odd  = 11'b10000001110;
    int  done_a = -1;
    int  done_c = -1;
    int  k = 0;
    @(negedge clk);
    ifa.tx_data = 8'h07; ifa.tx_valid = 1'b1;
    ifc.tx_data = 8'h07; ifc.tx_valid = 1'b1;
    while ((ifa.tx_ready !== 1'b1 || ifc.tx_ready !== 1'b1) && k < 200) begin @(negedge clk); k++; end
    n_checks++; if (k >= 200) begin n_fail++; $display("FAIL parity_accept got timeout want accept"); end
    @(posedge clk);
    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      if (c == 0) begin ifa.tx_valid = 1'b0; ifc.tx_valid = 1'b0; end
      if (c < 44 && c % 4 == 2) begin
        n_checks++;
        if (ifa.tx !== exp_even[c/4]) begin n_fail++; $display("FAIL parity_even_bit%0d got %b want %b", c/4, ifa.tx, exp_even[c/4]); end
        n_checks++;
        if (ifc.tx !== exp_odd[c/4]) begin n_fail++; $display("FAIL parity_odd_bit%0d got %b want %b", c/4, ifc.tx, exp_odd[c/4]); end
      end
      if (ifa.txdone === 1'b1) done_a = c;
      if (ifc.txdone === 1'b1) done_c = c;
    end
    n_checks++; if (done_a != 43 || done_c != 43) begin
      n_fail++; $display("FAIL parity_done got a=%0d c=%0d want 43 43", done_a, done_c);
    end
    $display("frames a/c: sent 0x07 with even and odd parity");
  endtask
`endif

  initial begin
    ifa.tx_data = '0; ifa.tx_valid = 1'b0;
    ifb.tx_data = '0; ifb.tx_valid = 1'b0;
    ifc.tx_data = '0; ifc.tx_valid = 1'b0;
    test_reset();
`ifdef UART_TX_PARITY_EN
    test_parity();
`else
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignore_valid();
`endif
    test_short_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
